tff_array: RTL and testbench
============================

Name: tff_array

Overview:
- Parametrised successor to the single-bit toggle flip-flop: a WIDTH-bit register bank with per-bit toggle/set/clear/load under a mask, plus whole-word increment/decrement.
- Used wherever the design needs a group of toggle flags, a mode register with bit-level updates, or a small event counter.
- One operation per cycle, selected by an opcode and qualified by a valid strobe.
- Registered terminal-count pulse and a zero flag for downstream control logic.

Parameters:
- WIDTH, 8, number of register bits; legal range 1..32.
- RESET_VAL, 0, value loaded into q on reset; truncated to WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- valid  input  1  qualifies op; when 0 the bank holds.
- op  input  3  operation code, sampled only when valid=1.
- mask  input  WIDTH  per-bit select for TOGGLE/SET/CLEAR/LOAD; ignored by INC/DEC.
- din  input  WIDTH  load data for LOAD.
- q  output  WIDTH  register contents.
- tc  output  1  registered one-cycle terminal-count pulse.
- zero  output  1  high when q == 0; decoded from the registered q with no extra latency.

Behaviour:
- Reset is synchronous and active-high on clk, and takes priority over everything: q <= RESET_VAL, tc <= 0. zero follows q, so it is 1 iff RESET_VAL == 0.
- All updates take effect on the rising edge where valid=1. The new q is visible in the following cycle (1-cycle latency).
- valid=0: q holds; tc <= 0.
- Opcodes with valid=1:
  - 0 HOLD: q unchanged.
  - 1 TOGGLE: q <= q ^ mask.
  - 2 SET: q <= q | mask.
  - 3 CLEAR: q <= q & ~mask.
  - 4 LOAD: q <= (q & ~mask) | (din & mask).
  - 5 INC: q <= q + 1, modulo 2^WIDTH.
  - 6 DEC: q <= q - 1, modulo 2^WIDTH.
  - 7 reserved: behaves as HOLD, no side effects.
- mask = 0 makes TOGGLE/SET/CLEAR/LOAD equivalent to HOLD. mask = all-ones makes LOAD a full-word load.
- tc:
  - Set to 1 on the edge where an INC is applied with q == all-ones, or a DEC is applied with q == 0.
  - Cleared to 0 on every other edge. It is therefore a single-cycle pulse aligned with the updated q.
  - Back-to-back wrapping operations produce tc high in consecutive cycles.
- Arithmetic is unsigned, WIDTH bits. The carry/borrow out is used only to generate tc and is never stored.
- Reset asserted in the same cycle as valid=1: reset wins, and the op is discarded.
- WIDTH=1:
  - INC and DEC both invert the bit.
  - tc pulses on INC from 1 and on DEC from 0.
- No internal state beyond q and tc. The block is fully re-entrant every cycle with no busy period.

Optional Feature:
- Macro: TFF_ARRAY_SAT_EN.
- Defined: INC at q == all-ones leaves q at all-ones, and DEC at q == 0 leaves q at 0 (saturating). tc still pulses on these attempts to flag the overflow/underflow.
- Not defined: INC/DEC wrap modulo 2^WIDTH as described above.
- Bitwise ops are identical in both builds.

Test Plan:
- Reset: WIDTH=8, RESET_VAL=8'hA5, assert reset for 2 cycles with valid=1, op=5 -> q=8'hA5, tc=0, zero=0 after release; op discarded.
- Bitwise ops: from q=8'h00:
  - SET mask=8'hF0 -> q=8'hF0.
  - TOGGLE mask=8'hFF -> q=8'h0F.
  - CLEAR mask=8'h03 -> q=8'h0C.
  - LOAD mask=8'h0F din=8'h37 -> q=8'h07.
  - tc stays 0 throughout.
- Wrap up: q=8'hFE, three INC cycles -> q=8'hFF, 8'h00, 8'h01; tc=0,1,0; zero=0,1,0. With TFF_ARRAY_SAT_EN: q=8'hFF, 8'hFF, 8'hFF; tc=0,1,1.
- Wrap down: q=8'h01, two DEC cycles -> q=8'h00 (zero=1, tc=0), then q=8'hFF (tc=1). With TFF_ARRAY_SAT_EN: second cycle gives q=8'h00, tc=1.
- Hold conditions: q=8'h5A; valid=0 with op=1 mask=8'hFF for 4 cycles, then valid=1 op=7, then valid=1 op=1 mask=8'h00 -> q=8'h5A throughout, tc=0.
- WIDTH=1 instance, RESET_VAL=0: INC, INC, DEC -> q=1,0,1; tc=0,1,1.

Source files
------------

// File: rtl/tff_array.sv
// ---------------------------------------------------------------------------
// tff_array
//
// WIDTH-bit register bank with per-bit toggle/set/clear/load under a mask,
// plus whole-word increment/decrement. One operation per cycle, selected by
// op and qualified by valid. A registered one-cycle terminal-count pulse (tc)
// flags INC from all-ones and DEC from zero; zero is decoded combinationally
// from the registered q.
//
// Parameters:
//   WIDTH      number of register bits, 1..32
//   RESET_VAL  value loaded into q on reset (truncated to WIDTH bits)
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high reset (priority over everything)
//   valid  in   qualifies op; bank holds when low
//   op     in   3-bit opcode:
//                 0 HOLD, 1 TOGGLE, 2 SET, 3 CLEAR, 4 LOAD, 5 INC, 6 DEC,
//                 7 reserved (HOLD)
//   mask   in   per-bit select for TOGGLE/SET/CLEAR/LOAD
//   din    in   load data for LOAD
//   q      out  register contents
//   tc     out  registered terminal-count pulse
//   zero   out  q == 0
//
// Optional feature:
//   TFF_ARRAY_SAT_EN  when defined, INC/DEC saturate at all-ones/zero instead
//                     of wrapping; tc still pulses on the saturating attempt.
// ---------------------------------------------------------------------------
module tff_array #(
    parameter int          WIDTH     = 8,
    parameter logic [31:0] RESET_VAL = 32'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] mask,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             zero
);

    localparam logic [WIDTH-1:0] RESET_Q = RESET_VAL[WIDTH-1:0];

    localparam logic [2:0] OP_HOLD   = 3'd0;
    localparam logic [2:0] OP_TOGGLE = 3'd1;
    localparam logic [2:0] OP_SET    = 3'd2;
    localparam logic [2:0] OP_CLEAR  = 3'd3;
    localparam logic [2:0] OP_LOAD   = 3'd4;
    localparam logic [2:0] OP_INC    = 3'd5;
    localparam logic [2:0] OP_DEC    = 3'd6;

    logic [WIDTH-1:0] q_next;
    logic             tc_next;
    logic             q_all_ones;
    logic             q_is_zero;

    assign q_all_ones = (q == {WIDTH{1'b1}});
    assign q_is_zero  = (q == '0);

    always_comb begin
        q_next  = q;
        tc_next = 1'b0;
        if (valid) begin
            case (op)
                OP_HOLD:   q_next = q;
                OP_TOGGLE: q_next = q ^ mask;
                OP_SET:    q_next = q | mask;
                OP_CLEAR:  q_next = q & ~mask;
                OP_LOAD:   q_next = (q & ~mask) | (din & mask);
                OP_INC: begin
                    // carry out only drives tc; it is never stored
                    tc_next = q_all_ones;
`ifdef TFF_ARRAY_SAT_EN
                    if (!q_all_ones)
                        q_next = q + 1'b1;
`else
                    q_next = q + 1'b1;
`endif
                end
                OP_DEC: begin
                    tc_next = q_is_zero;
`ifdef TFF_ARRAY_SAT_EN
                    if (!q_is_zero)
                        q_next = q - 1'b1;
`else
                    q_next = q - 1'b1;
`endif
                end
                default:   q_next = q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q  <= RESET_Q;
            tc <= 1'b0;
        end else begin
            q  <= q_next;
            tc <= tc_next;
        end
    end

    assign zero = q_is_zero;

endmodule

// File: tb/tb_tff_array.sv
module tb_tff_array;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;

    // 8-bit instance, RESET_VAL = 8'hA5
    logic       v8;
    logic [2:0] op8;
    logic [7:0] mask8, din8, q8;
    logic       tc8, zero8;

    // 1-bit instance, RESET_VAL = 0
    logic       v1;
    logic [2:0] op1;
    logic [0:0] mask1, din1, q1;
    logic       tc1, zero1;

    tff_array #(.WIDTH(8), .RESET_VAL(32'hA5)) dut8 (
        .clk(clk), .reset(reset), .valid(v8), .op(op8), .mask(mask8),
        .din(din8), .q(q8), .tc(tc8), .zero(zero8)
    );

    tff_array #(.WIDTH(1), .RESET_VAL(32'h0)) dut1 (
        .clk(clk), .reset(reset), .valid(v1), .op(op1), .mask(mask1),
        .din(din1), .q(q1), .tc(tc1), .zero(zero1)
    );

`ifdef TFF_ARRAY_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: plain integer arithmetic over a modulus of 2**w.
    function automatic longint model_q(input int w, input longint qv, input logic v,
                                       input logic [2:0] o, input longint m, input longint d);
        longint modulus = longint'(1) << w;
        longint top     = modulus - 1;
        if (!v) return qv;
        case (o)
            3'd1: return (qv ^ m) & top;
            3'd2: return (qv | m) & top;
            3'd3: return qv & ~m & top;
            3'd4: return (qv & ~m & top) | (d & m);
            3'd5: return (qv + 1 == modulus) ? (SAT ? qv : 0) : qv + 1;
            3'd6: return (qv == 0) ? (SAT ? 0 : top) : qv - 1;
            default: return qv;
        endcase
    endfunction

    function automatic bit model_tc(input int w, input longint qv, input logic v,
                                    input logic [2:0] o);
        longint modulus = longint'(1) << w;
        if (!v) return 1'b0;
        if (o == 3'd5) return (qv + 1 == modulus);
        if (o == 3'd6) return (qv == 0);
        return 1'b0;
    endfunction

    longint mq8, mq1;
    bit     mtc8, mtc1;
    bit     started = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            mq8     <= 64'hA5;
            mtc8    <= 1'b0;
            mq1     <= 0;
            mtc1    <= 1'b0;
            started <= 1'b1;
        end else begin
            mq8  <= model_q(8, mq8, v8, op8, longint'(mask8), longint'(din8));
            mtc8 <= model_tc(8, mq8, v8, op8);
            mq1  <= model_q(1, mq1, v1, op1, longint'(mask1), longint'(din1));
            mtc1 <= model_tc(1, mq1, v1, op1);
        end
    end

    // Cycle-by-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("model q8", longint'(q8), mq8);
            chk("model tc8", longint'(tc8), longint'(mtc8));
            chk("model zero8", longint'(zero8), longint'(mq8 == 0));
            chk("model q1", longint'(q1), mq1);
            chk("model tc1", longint'(tc1), longint'(mtc1));
            chk("model zero1", longint'(zero1), longint'(mq1 == 0));
        end
    end

    // Drive one 8-bit operation and check hand-computed literals after the edge.
    task automatic step8(input string name, input logic v, input logic [2:0] o,
                         input logic [7:0] m, input logic [7:0] d,
                         input logic [7:0] eq, input logic etc);
        @(negedge clk);
        v8 = v; op8 = o; mask8 = m; din8 = d;
        @(posedge clk);
        #1;
        chk({name, " q"}, longint'(q8), longint'(eq));
        chk({name, " tc"}, longint'(tc8), longint'(etc));
        chk({name, " zero"}, longint'(zero8), longint'(eq == 8'h00));
    endtask

    task automatic step1(input string name, input logic [2:0] o,
                         input logic eq, input logic etc);
        @(negedge clk);
        v1 = 1'b1; op1 = o;
        @(posedge clk);
        #1;
        chk({name, " q"}, longint'(q1), longint'(eq));
        chk({name, " tc"}, longint'(tc1), longint'(etc));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        v8 = 1'b1; op8 = 3'd5; mask8 = 8'h00; din8 = 8'h00;
        v1 = 1'b0; op1 = 3'd0; mask1 = 1'b0; din1 = 1'b0;

        // Reset for 2 cycles with an INC pending: op must be discarded.
        repeat (2) @(posedge clk);
        #1;
        chk("reset q", longint'(q8), 64'hA5);
        chk("reset tc", longint'(tc8), 0);
        chk("reset zero", longint'(zero8), 0);
        chk("reset q1", longint'(q1), 0);
        chk("reset zero1", longint'(zero1), 1);
        @(negedge clk);
        reset = 1'b0; v8 = 1'b0;

        // Bitwise ops from 0
        step8("clr all", 1, 3'd4, 8'hFF, 8'h00, 8'h00, 0);
        step8("set",     1, 3'd2, 8'hF0, 8'h00, 8'hF0, 0);
        step8("toggle",  1, 3'd1, 8'hFF, 8'h00, 8'h0F, 0);
        step8("clear",   1, 3'd3, 8'h03, 8'h00, 8'h0C, 0);
        step8("load",    1, 3'd4, 8'h0F, 8'h37, 8'h07, 0);

        // Wrap up
        step8("ld FE",   1, 3'd4, 8'hFF, 8'hFE, 8'hFE, 0);
        step8("inc1",    1, 3'd5, 8'h00, 8'h00, 8'hFF, 0);
        step8("inc2",    1, 3'd5, 8'h00, 8'h00, SAT ? 8'hFF : 8'h00, 1);
        step8("inc3",    1, 3'd5, 8'h00, 8'h00, SAT ? 8'hFF : 8'h01, SAT);

        // Wrap down
        step8("ld 01",   1, 3'd4, 8'hFF, 8'h01, 8'h01, 0);
        step8("dec1",    1, 3'd6, 8'h00, 8'h00, 8'h00, 0);
        step8("dec2",    1, 3'd6, 8'h00, 8'h00, SAT ? 8'h00 : 8'hFF, 1);

        // Hold conditions
        step8("ld 5A",   1, 3'd4, 8'hFF, 8'h5A, 8'h5A, 0);
        for (int i = 0; i < 4; i++)
            step8("novalid", 0, 3'd1, 8'hFF, 8'h00, 8'h5A, 0);
        step8("op7",     1, 3'd7, 8'hFF, 8'hFF, 8'h5A, 0);
        step8("mask0",   1, 3'd1, 8'h00, 8'h00, 8'h5A, 0);
        step8("set m0",  1, 3'd2, 8'h00, 8'h00, 8'h5A, 0);
        step8("dec 5A",  1, 3'd6, 8'h00, 8'h00, 8'h59, 0);
        step8("ld part", 1, 3'd4, 8'hC3, 8'h3C, 8'h18, 0);

        // DEC below zero pulses tc; back-to-back pulses on successive wraps
        step8("ld 00",   1, 3'd4, 8'hFF, 8'h00, 8'h00, 0);
        step8("dec0",    1, 3'd6, 8'h00, 8'h00, SAT ? 8'h00 : 8'hFF, 1);
        step8("inc b2b", 1, 3'd5, 8'h00, 8'h00, SAT ? 8'h01 : 8'h00, SAT ? 1'b0 : 1'b1);

        @(negedge clk);
        v8 = 1'b0;

        // WIDTH=1 instance
        step1("w1 inc1", 3'd5, 1'b1, 1'b0);
        step1("w1 inc2", 3'd5, SAT ? 1'b1 : 1'b0, 1'b1);
        step1("w1 dec",  3'd6, SAT ? 1'b0 : 1'b1, SAT ? 1'b0 : 1'b1);

        // Reset mid-run with a valid op: reset wins
        @(negedge clk);
        reset = 1'b1; v8 = 1'b1; op8 = 3'd1; mask8 = 8'hFF; v1 = 1'b1; op1 = 3'd5;
        @(posedge clk);
        #1;
        chk("rst2 q", longint'(q8), 64'hA5);
        chk("rst2 tc", longint'(tc8), 0);
        chk("rst2 q1", longint'(q1), 0);
        @(negedge clk);
        reset = 1'b0; v8 = 1'b0; v1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
